bpf16_decimator: RTL and testbench

Boxcar-average decimator that sits directly downstream of the BPF16 FIR core. It consumes the core's 16-bit signed Q1.14 output stream over a valid/ready handshake and averages blocks of N = 2^k samples, with k selected at run time from 0 to 3. It rounds each block to one output sample and buffers results in a small FIFO so the FIR is not stalled while the downstream consumer is busy.

---
 rtl/bpf16_decimator.sv | 118 +++++++++++
 tb/tb_bpf16_decimator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpf16_decimator.sv
// Boxcar-average decimator: averages blocks of 2^k Q1.14 samples, rounds half-up, buffers results in a FIFO.
// Latency 1 cycle from block-end acceptance to dout_valid; din_ready stalls only at block edges when the FIFO is full.
module bpf16_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LOG2   = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    input  logic [1:0]                    decim_log2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = DATA_WIDTH + MAX_LOG2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [AW-1:0] ONE     = 1;
    localparam logic signed [AW-1:0] SAT_MAX = signed'({{(MAX_LOG2+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = signed'({{(MAX_LOG2+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

    logic [MAX_LOG2-1:0]   phase;
    logic [1:0]            active_k;
    logic signed [AW-1:0]  acc;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [1:0]            k_eff;
    logic [MAX_LOG2-1:0]   act_last;
    logic [MAX_LOG2-1:0]   eff_last;
    logic                  full;
    logic                  in_fire;
    logic                  out_fire;
    logic                  blk_end;
    logic signed [AW-1:0]  din_ext;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  half;
    logic signed [AW-1:0]  rnd_sum;
    logic signed [AW-1:0]  shifted;
    logic [DATA_WIDTH-1:0] result;

    // A new block latches decim_log2 on its first sample, so that sample already uses the new k.
    assign k_eff    = (phase == '0) ? decim_log2 : active_k;
    assign act_last = ~({MAX_LOG2{1'b1}} << active_k);
    assign eff_last = ~({MAX_LOG2{1'b1}} << k_eff);

    assign full      = (count == CW'(FIFO_DEPTH));
    assign din_ready = ((phase != act_last) && (phase != '0)) || !full;
    assign in_fire   = din_valid && din_ready;
    assign out_fire  = dout_valid && dout_ready;
    assign blk_end   = in_fire && (phase == eff_last);

    assign din_ext = {{MAX_LOG2{din[DATA_WIDTH-1]}}, din};
    assign sum     = (phase == '0) ? din_ext : acc + din_ext;
    assign half    = (ONE << k_eff) >> 1;
    assign rnd_sum = sum + half;
    assign shifted = rnd_sum >>> k_eff;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase    <= '0;
            acc      <= '0;
            active_k <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (in_fire) begin
                if (phase == '0) begin
                    active_k <= decim_log2;
                end
                if (blk_end) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                    acc   <= sum;
                end
            end
            if (blk_end) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({blk_end, out_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (blk_end) begin
            mem[wr_ptr] <= result;
        end
    end

    assign dout       = (count != '0) ? mem[rd_ptr] : '0;
    assign dout_valid = (count != '0);
    assign fifo_level = count;

endmodule

// File: tb/tb_bpf16_decimator.sv
// Scoreboard bench for bpf16_decimator: a negedge monitor models acceptance and averaging, queues expected outputs and checks handshakes.
module tb_bpf16_decimator;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [1:0]    decim_log2;
    logic [2:0]    fifo_level;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int got_q[$];

    int m_phase = 0;
    int m_acc   = 0;
    int m_k     = 0;
    int m_cnt, m_last, m_kk, m_dv, m_r, m_e;
    bit m_rdy;

    bpf16_decimator #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_LOG2(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .decim_log2 (decim_log2),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge; here at negedge we see what the next posedge will do.
    always @(negedge clk) begin
        if (!rstn) begin
            m_phase = 0;
            m_acc   = 0;
            m_k     = 0;
            exp_q.delete();
        end else begin
            m_cnt  = exp_q.size();
            m_last = (1 << m_k) - 1;
            m_rdy  = ((m_phase != m_last) && (m_phase != 0)) || (m_cnt != DEPTH);
            checks++;
            if (din_ready !== m_rdy) begin
                failures++;
                $display("FAIL din_ready t=%0t got=%b exp=%b", $time, din_ready, m_rdy);
            end
            checks++;
            if (dout_valid !== (m_cnt != 0)) begin
                failures++;
                $display("FAIL dout_valid t=%0t got=%b exp=%b", $time, dout_valid, m_cnt != 0);
            end
            checks++;
            if (fifo_level !== 3'(m_cnt)) begin
                failures++;
                $display("FAIL fifo_level t=%0t got=%0d exp=%0d", $time, fifo_level, m_cnt);
            end
            if (m_cnt == 0) begin
                checks++;
                if (dout !== '0) begin
                    failures++;
                    $display("FAIL dout_empty t=%0t got=%0d exp=0", $time, dout);
                end
            end
            if (dout_valid && dout_ready && m_cnt > 0) begin
                m_e  = exp_q.pop_front();
                m_dv = $signed(dout);
                checks++;
                if (m_dv !== m_e) begin
                    failures++;
                    $display("FAIL dout_data t=%0t got=%0d exp=%0d", $time, m_dv, m_e);
                end
                got_q.push_back(m_dv);
            end
            if (din_valid && din_ready) begin
                m_dv = $signed(din);
                m_kk = (m_phase == 0) ? int'(decim_log2) : m_k;
                m_k  = m_kk;
                m_acc = (m_phase == 0) ? m_dv : m_acc + m_dv;
                if (m_phase == (1 << m_kk) - 1) begin
                    m_r = (m_kk == 0) ? m_acc : ((m_acc + (1 << (m_kk - 1))) >>> m_kk);
                    if (m_r > 32767) m_r = 32767;
                    if (m_r < -32768) m_r = -32768;
                    exp_q.push_back(m_r);
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
        end
    end

    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        din = 16'(v);
        din_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got=stalled exp=accepted value=%0d", v);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !dout_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout got=%0d left exp=0", exp_q.size());
        end
    endtask

    task automatic check_got(input string name, input int exp[]);
        checks++;
        if (got_q.size() != exp.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (got_q[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%0d exp=%0d", name, i, got_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (dout_valid !== 1'b0 || fifo_level !== 3'd0 || din_ready !== 1'b1 || dout !== '0) begin
            failures++;
            $display("FAIL reset_state got=v%b l%0d r%b d%0d exp=v0 l0 r1 d0", dout_valid, fifo_level, din_ready, dout);
        end
    endtask

    task automatic test_passthrough();
        got_q.delete();
        decim_log2 = 2'd0;
        dout_ready = 1'b1;
        send(100);
        send(-5);
        send(32767);
        drain();
        check_got("passthrough", '{100, -5, 32767});
    endtask

    task automatic test_k2_rounding();
        got_q.delete();
        decim_log2 = 2'd2;
        dout_ready = 1'b1;
        send(1); send(2); send(3); send(4);
        send(-1); send(-2); send(-2); send(-2);
        for (int i = 0; i < 4; i++) send(32767);
        drain();
        check_got("k2_round", '{3, -2, 32767});
    endtask

    task automatic test_mid_block_k();
        got_q.delete();
        decim_log2 = 2'd1;
        dout_ready = 1'b1;
        send(10);
        decim_log2 = 2'd3;
        send(20);
        for (int i = 0; i < 8; i++) send(8);
        drain();
        check_got("mid_k", '{15, 8});
    endtask

    task automatic test_backpressure();
        got_q.delete();
        decim_log2 = 2'd0;
        dout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i * 11);
        checks++;
        if (fifo_level !== 3'd4 || din_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full got=l%0d r%b exp=l4 r0", fifo_level, din_ready);
        end
        din = 16'd55;
        din_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (fifo_level !== 3'd4 || din_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got=l%0d r%b exp=l4 r0", fifo_level, din_ready);
        end
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || din_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_pop got=l%0d r%b exp=l3 r1", fifo_level, din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4) begin
            failures++;
            $display("FAIL bp_refill got=%0d exp=4", fifo_level);
        end
        drain();
        check_got("backpressure", '{11, 22, 33, 44, 55});
    endtask

    task automatic test_random();
        got_q.delete();
        for (int i = 0; i < 200; i++) begin
            decim_log2 = (i < 100) ? 2'd1 : 2'($urandom_range(0, 3));
            din_valid  = 1'($urandom_range(0, 1));
            din        = 16'($urandom);
            dout_ready = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_left got=%0d exp=0", exp_q.size());
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_op();
        decim_log2 = 2'd2;
        dout_ready = 1'b0;
        for (int i = 0; i < 14; i++) send(1000 + i);
        checks++;
        if (fifo_level !== 3'd3) begin
            failures++;
            $display("FAIL rst_setup got=%0d exp=3", fifo_level);
        end
        pulse_reset();
        checks++;
        if (dout_valid !== 1'b0 || fifo_level !== 3'd0 || din_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got=v%b l%0d r%b exp=v0 l0 r1", dout_valid, fifo_level, din_ready);
        end
        got_q.delete();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(4);
        drain();
        check_got("rst_after", '{4});
    endtask

    initial begin
        rstn       = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        decim_log2 = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        test_reset();
        test_passthrough();
        test_k2_rounding();
        test_mid_block_k();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
